// File: rtl/mem_player.sv
`default_nettype none
// ============================================================================
// Module   : mem_player
// Purpose  : Plays a range of RAM words out as a held sample stream. It holds
//            each sample for period+3 cycles and supports single-shot, loop
//            and optional ping-pong playback over a range that may wrap.
// Options  : define MEM_PLAYER_PINGPONG_EN to build the ping-pong direction
//            logic; without it the pingpong input is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mem_player #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 1152,
  parameter  int PBITS = 24,
  localparam int ABITS = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [ABITS-1:0] first_addr,
  input  logic [ABITS-1:0] last_addr,
  input  logic [PBITS-1:0] period,
  input  logic             loop,
  input  logic             pingpong,
  output logic [ABITS-1:0] raddr,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [ABITS-1:0] C_TOP = ABITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state, nxt_state;
  logic [ABITS-1:0] r_index, nxt_index;
  logic [PBITS-1:0] r_hold_cnt, nxt_hold_cnt;
  logic [WIDTH-1:0] r_dout, nxt_dout;
  logic             r_dout_valid, nxt_dout_valid;
  logic             r_done, nxt_done;

  // Playback settings captured at start so later input changes are harmless.
  logic [ABITS-1:0] r_first, nxt_first;
  logic [ABITS-1:0] r_last, nxt_last;
  logic [PBITS-1:0] r_period, nxt_period;
  logic             r_loop, nxt_loop;

  logic [ABITS-1:0] w_index_inc;
  logic [ABITS-1:0] w_index_step;
  logic [ABITS-1:0] w_range_end;

`ifdef MEM_PLAYER_PINGPONG_EN
  logic             r_pingpong, nxt_pingpong;
  logic             r_dir_up, nxt_dir_up;
  logic [ABITS-1:0] w_index_dec;
  logic [ABITS-1:0] w_turn_index;
  logic             w_turn;

  // Direction-aware neighbours; a bounce is skipped for single-address ranges
  // and for the final down leg of a non-looping run.
  always_comb begin
    w_index_inc  = (r_index == C_TOP) ? '0 : r_index + 1'b1;
    w_index_dec  = (r_index == '0) ? C_TOP : r_index - 1'b1;
    w_range_end  = r_dir_up ? r_last : r_first;
    w_index_step = r_dir_up ? w_index_inc : w_index_dec;
    w_turn_index = r_dir_up ? w_index_dec : w_index_inc;
    w_turn       = r_pingpong && (r_first != r_last) && (r_dir_up || r_loop);
  end
`else
  logic w_unused_pingpong;
  assign w_unused_pingpong = pingpong;

  // Upward-only stepping with wrap from the top word back to address 0.
  always_comb begin
    w_index_inc  = (r_index == C_TOP) ? '0 : r_index + 1'b1;
    w_index_step = w_index_inc;
    w_range_end  = r_last;
  end
`endif

  // Next-state and datapath decode; stop overrides everything else.
  always_comb begin
    nxt_state      = r_state;
    nxt_index      = r_index;
    nxt_hold_cnt   = r_hold_cnt;
    nxt_dout       = r_dout;
    nxt_dout_valid = 1'b0;
    nxt_done       = 1'b0;
    nxt_first      = r_first;
    nxt_last       = r_last;
    nxt_period     = r_period;
    nxt_loop       = r_loop;
`ifdef MEM_PLAYER_PINGPONG_EN
    nxt_pingpong   = r_pingpong;
    nxt_dir_up     = r_dir_up;
`endif
    if (stop) begin
      nxt_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            nxt_first  = first_addr;
            nxt_last   = last_addr;
            nxt_period = period;
            nxt_loop   = loop;
            nxt_index  = first_addr;
`ifdef MEM_PLAYER_PINGPONG_EN
            nxt_pingpong = pingpong;
            nxt_dir_up   = 1'b1;
`endif
            nxt_state  = S_READ;
          end
        end
        S_READ: begin
          // RAM read latency cycle.
          nxt_state = S_LATCH;
        end
        S_LATCH: begin
          nxt_dout       = rdata;
          nxt_dout_valid = 1'b1;
          nxt_hold_cnt   = '0;
          nxt_state      = S_HOLD;
        end
        S_HOLD: begin
          nxt_hold_cnt = r_hold_cnt + 1'b1;
          if (r_hold_cnt == r_period) begin
            nxt_state = S_READ;
            if (r_index != w_range_end) begin
              nxt_index = w_index_step;
            end
`ifdef MEM_PLAYER_PINGPONG_EN
            else if (w_turn) begin
              nxt_index  = w_turn_index;
              nxt_dir_up = ~r_dir_up;
            end
`endif
            else if (r_loop) begin
              nxt_index = r_first;
            end else begin
              nxt_state = S_IDLE;
              nxt_done  = 1'b1;
            end
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_hold_cnt   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_first      <= '0;
      r_last       <= '0;
      r_period     <= '0;
      r_loop       <= 1'b0;
`ifdef MEM_PLAYER_PINGPONG_EN
      r_pingpong   <= 1'b0;
      r_dir_up     <= 1'b1;
`endif
    end else begin
      r_state      <= nxt_state;
      r_index      <= nxt_index;
      r_hold_cnt   <= nxt_hold_cnt;
      r_dout       <= nxt_dout;
      r_dout_valid <= nxt_dout_valid;
      r_done       <= nxt_done;
      r_first      <= nxt_first;
      r_last       <= nxt_last;
      r_period     <= nxt_period;
      r_loop       <= nxt_loop;
`ifdef MEM_PLAYER_PINGPONG_EN
      r_pingpong   <= nxt_pingpong;
      r_dir_up     <= nxt_dir_up;
`endif
    end
  end

  assign raddr      = r_index;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_player
// Purpose  : Self-checking bench for mem_player: table of playback vectors
//            plus directed reset, stop and start/stop collision sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_player;

  localparam int WIDTH = 16;
  localparam int DEPTH = 1152;
  localparam int PBITS = 8;
  localparam int ABITS = $clog2(DEPTH);

  logic             CLK;
  logic             reset;
  logic             start;
  logic             stop;
  logic [ABITS-1:0] first_addr;
  logic [ABITS-1:0] last_addr;
  logic [PBITS-1:0] period;
  logic             loop;
  logic             pingpong;
  logic [ABITS-1:0] raddr;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  mem_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PBITS(PBITS)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .period     (period),
    .loop       (loop),
    .pingpong   (pingpong),
    .raddr      (raddr),
    .rdata      (rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: word i holds value i, one-cycle registered read.
  always @(posedge CLK) rdata <= WIDTH'(raddr);

  typedef struct packed {
    logic [ABITS-1:0]      first;
    logic [ABITS-1:0]      last;
    logic [PBITS-1:0]      per;
    logic                  lp;
    logic                  pp;
    logic                  poke;
    logic [3:0]            n;
    logic [5:0][WIDTH-1:0] exp_s;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int f, input int l, input int p, input bit lp, input bit pp,
                              input bit poke, input int n, input int s0, input int s1,
                              input int s2, input int s3, input int s4, input int s5);
    vec_t v;
    v.first    = ABITS'(f);
    v.last     = ABITS'(l);
    v.per      = PBITS'(p);
    v.lp       = lp;
    v.pp       = pp;
    v.poke     = poke;
    v.n        = 4'(n);
    v.exp_s[0] = WIDTH'(s0);
    v.exp_s[1] = WIDTH'(s1);
    v.exp_s[2] = WIDTH'(s2);
    v.exp_s[3] = WIDTH'(s3);
    v.exp_s[4] = WIDTH'(s4);
    v.exp_s[5] = WIDTH'(s5);
    return v;
  endfunction

  // One-cycle start pulse with the given settings; returns on the next negedge.
  task automatic begin_play(input int f, input int l, input int p, input bit lp, input bit pp);
    first_addr = ABITS'(f);
    last_addr  = ABITS'(l);
    period     = PBITS'(p);
    loop       = lp;
    pingpong   = pp;
    start      = 1'b1;
    @(negedge CLK);
    start      = 1'b0;
  endtask

  // Runs one non-looping vector to completion and checks values, cadence and done.
  task automatic run_vec(input vec_t v);
    int  got;
    int  last_v;
    bit  seen_done;
    bit  fin;
    begin_play(int'(v.first), int'(v.last), int'(v.per), v.lp, v.pp);
    // Scramble the inputs: the latched settings must govern the run.
    first_addr = ABITS'(100);
    last_addr  = ABITS'(100);
    period     = PBITS'(9);
    loop       = ~v.lp;
    pingpong   = ~v.pp;
    got = 0; last_v = 0; seen_done = 1'b0; fin = 1'b0;
    for (int t = 0; t < 400 && !fin; t++) begin
      if (dout_valid) begin
        if (got == 0) check("first_latency", t, 2);
        else          check("sample_spacing", t - last_v, int'(v.per) + 3);
        if (got < int'(v.n)) check("sample_value", dout, v.exp_s[got]);
        got++;
        last_v = t;
      end
      if (done) begin
        check("done_delay", t - last_v, int'(v.per) + 1);
        check("busy_at_done", busy, 0);
        seen_done = 1'b1;
        fin = 1'b1;
      end else if (busy !== 1'b1) begin
        check("busy_during_play", busy, 1);
        fin = 1'b1;
      end
      start = (v.poke && t == 4);
      @(negedge CLK);
      start = 1'b0;
    end
    check("sample_count", got, int'(v.n));
    check("done_seen", seen_done, 1);
    check("done_single_pulse", done, 0);
    @(negedge CLK);
  endtask

  // Looping run that is stopped right after the n-th strobe (mid-HOLD or READ).
  task automatic loop_and_stop(input int f, input int l, input int p, input int n);
    int  got;
    int  last_v;
    int  bad;
    logic [WIDTH-1:0] held;
    begin_play(f, l, p, 1'b1, 1'b0);
    got = 0; last_v = 0; held = '0;
    for (int t = 0; t < 200 && got < n; t++) begin
      if (done) check("loop_no_done", done, 0);
      if (dout_valid) begin
        if (got > 0) check("loop_spacing", t - last_v, p + 3);
        check("loop_value", dout, WIDTH'(f + (got % (l - f + 1))));
        held = dout;
        got++;
        last_v = t;
      end
      if (got < n) @(negedge CLK);
    end
    check("loop_strobes", got, n);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    check("stop_dout_kept", dout, held);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (done || dout_valid || busy) bad++;
    end
    check("stop_stays_idle", bad, 0);
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    first_addr = '0; last_addr = '0; period = '0; loop = 1'b0; pingpong = 1'b0;

    vecs[0] = mk(4, 6, 2, 1'b0, 1'b0, 1'b0, 3, 4, 5, 6, 0, 0, 0);
    vecs[1] = mk(1150, 1, 0, 1'b0, 1'b0, 1'b0, 4, 1150, 1151, 0, 1, 0, 0);
    vecs[2] = mk(9, 9, 1, 1'b0, 1'b0, 1'b0, 1, 9, 0, 0, 0, 0, 0);
`ifdef MEM_PLAYER_PINGPONG_EN
    vecs[3] = mk(2, 4, 0, 1'b0, 1'b1, 1'b0, 5, 2, 3, 4, 3, 2, 0);
`else
    vecs[3] = mk(2, 4, 0, 1'b0, 1'b1, 1'b0, 3, 2, 3, 4, 0, 0, 0);
`endif
    vecs[4] = mk(4, 6, 1, 1'b0, 1'b0, 1'b1, 3, 4, 5, 6, 0, 0, 0);
    vecs[5] = mk(1151, 1151, 3, 1'b0, 1'b0, 1'b0, 1, 1151, 0, 0, 0, 0, 0);
    vecs[6] = mk(0, 2, 5, 1'b0, 1'b0, 1'b0, 3, 0, 1, 2, 0, 0, 0);

    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_done", done, 0);
    check("rst_raddr", raddr, 0);
    reset = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Looping playback, then stop.
    loop_and_stop(7, 7, 2, 3);
    loop_and_stop(3, 4, 0, 5);

    // start together with stop from IDLE: stop wins.
    first_addr = ABITS'(5); last_addr = ABITS'(6); period = '0; loop = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(negedge CLK);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (busy || dout_valid || done) bad++;
    end
    check("startstop_stays_idle", bad, 0);

    // Reset mid-HOLD, with a start pulse during reset to confirm reset priority.
    begin_play(5, 7, 4, 1'b0, 1'b0);
    bad = 0;
    for (int t = 0; t < 20 && !dout_valid; t++) @(negedge CLK);
    check("pre_reset_dout", dout, 5);
    @(negedge CLK);
    reset = 1'b1; start = 1'b1;
    @(negedge CLK);
    reset = 1'b0; start = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_dout", dout, 0);
    check("midrst_raddr", raddr, 0);
    check("midrst_done", done, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (busy || done || dout_valid) bad++;
    end
    check("midrst_stays_idle", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
